// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART transmitter: register map, shifter
// states and accepted character sizes.
package uart_pkg;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_ERROR  = 3'd1;
    localparam logic [2:0] ADDR_BP_LO  = 3'd2;
    localparam logic [2:0] ADDR_BP_HI  = 3'd3;
    localparam logic [2:0] ADDR_DSIZE  = 3'd4;
    localparam logic [2:0] ADDR_RSVD5  = 3'd5;
    localparam logic [2:0] ADDR_TXDATA = 3'd6;
    localparam logic [2:0] ADDR_RSVD7  = 3'd7;

    localparam logic [3:0] DSIZE_5 = 4'd5;
    localparam logic [3:0] DSIZE_7 = 4'd7;
    localparam logic [3:0] DSIZE_8 = 4'd8;

    localparam logic [13:0] MIN_PERIOD = 14'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic logic is_valid_size(input logic [3:0] size);
        return (size == DSIZE_5) || (size == DSIZE_7) || (size == DSIZE_8);
    endfunction

endpackage

// File: rtl/apb_uart_tx_if.sv
// APB slave bus bundle for the UART transmitter (no wait states, 3-bit address).
interface apb_uart_tx_if;
    logic       psel;
    logic [2:0] paddr;
    logic       penable;
    logic       pwrite;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pslverr;

    modport master (
        output psel, paddr, penable, pwrite, pwdata,
        input  prdata, pslverr
    );

    modport slave (
        input  psel, paddr, penable, pwrite, pwdata,
        output prdata, pslverr
    );
endinterface

// File: rtl/uart_tx_shifter.sv
// UART frame serialiser: start bit, LSB-first data, stop bit, each lasting
// load_period clocks. Takes a new byte from the holding register via load_ack.
module uart_tx_shifter
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic [7:0]  load_byte,
    input  logic [3:0]  load_size,
    input  logic [13:0] load_period,
    output logic        load_ack,
    output logic        busy,
    output logic        serial_out
);

    tx_state_t   state_r, state_nxt_s;
    logic [13:0] cnt_r, cnt_nxt_s;
    logic [13:0] period_r, period_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s;
    logic [3:0]  size_r, size_nxt_s;
    logic [3:0]  bits_r, bits_nxt_s;
    logic        serial_r, serial_nxt_s;
    logic        load_ack_s;

    // Next-state, counters and line level for the frame sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        period_nxt_s = period_r;
        shift_nxt_s  = shift_r;
        size_nxt_s   = size_r;
        bits_nxt_s   = bits_r;
        serial_nxt_s = serial_r;
        load_ack_s   = 1'b0;

        case (state_r)
            IDLE: begin
                serial_nxt_s = 1'b1;
                if (load_req) begin
                    load_ack_s   = 1'b1;
                    shift_nxt_s  = load_byte;
                    size_nxt_s   = load_size;
                    period_nxt_s = load_period;
                    cnt_nxt_s    = load_period - 14'd1;
                    serial_nxt_s = 1'b0;
                    state_nxt_s  = START;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            START: begin
                if (cnt_r == 14'd0) begin
                    serial_nxt_s = shift_r[0];
                    bits_nxt_s   = size_r - 4'd1;
                    cnt_nxt_s    = period_r - 14'd1;
                    state_nxt_s  = DATA;
                end else begin
                    cnt_nxt_s    = cnt_r - 14'd1;
                end
            end
            DATA: begin
                if (cnt_r == 14'd0) begin
                    cnt_nxt_s = period_r - 14'd1;
                    if (bits_r == 4'd0) begin
                        serial_nxt_s = 1'b1;
                        state_nxt_s  = STOP;
                    end else begin
                        // bits_r counts the bits still to send after the current one
                        serial_nxt_s = shift_r[1];
                        shift_nxt_s  = {1'b0, shift_r[7:1]};
                        bits_nxt_s   = bits_r - 4'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 14'd1;
                end
            end
            STOP: begin
                if (cnt_r == 14'd0) begin
                    if (load_req) begin
                        load_ack_s   = 1'b1;
                        shift_nxt_s  = load_byte;
                        size_nxt_s   = load_size;
                        period_nxt_s = load_period;
                        cnt_nxt_s    = load_period - 14'd1;
                        serial_nxt_s = 1'b0;
                        state_nxt_s  = START;
                    end else begin
                        serial_nxt_s = 1'b1;
                        state_nxt_s  = IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 14'd1;
                end
            end
            default: begin
                serial_nxt_s = 1'b1;
                state_nxt_s  = IDLE;
            end
        endcase
    end

    // Sequencer state register; reset drops any frame in flight and idles the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 14'd0;
            period_r <= MIN_PERIOD;
            shift_r  <= 8'd0;
            size_r   <= DSIZE_8;
            bits_r   <= 4'd0;
            serial_r <= 1'b1;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            period_r <= period_nxt_s;
            shift_r  <= shift_nxt_s;
            size_r   <= size_nxt_s;
            bits_r   <= bits_nxt_s;
            serial_r <= serial_nxt_s;
        end
    end

    assign load_ack   = load_ack_s;
    assign busy       = (state_r != IDLE);
    assign serial_out = serial_r;

endmodule

// File: rtl/apb_uart_tx.sv
// APB-programmable UART transmitter: register decode, configuration,
// one-entry holding register and overrun flag around the frame serialiser.
module apb_uart_tx
    import uart_pkg::*;
#(
    parameter logic [13:0] RST_BIT_PERIOD = 14'd10,
    parameter logic [3:0]  RST_DATA_SIZE  = 4'd8
) (
    input  logic              clk,
    input  logic              rst,
    apb_uart_tx_if.slave      apb,
    output logic              serial_out
);

    logic [13:0] bit_period_r;
    logic [3:0]  data_size_r;
    logic [7:0]  hold_data_r;
    logic        hold_full_r;
    logic        overrun_r;

    logic        access_s;
    logic        wr_s;
    logic        rd_s;
    logic        err_s;
    logic [7:0]  rdata_s;
    logic [13:0] period_eff_s;
    logic        load_ack_s;
    logic        busy_s;

    assign access_s = apb.psel & apb.penable;
    assign wr_s     = access_s & apb.pwrite;
    assign rd_s     = apb.psel & ~apb.pwrite;

    // Periods below two clocks cannot produce a distinct bit time, so clamp.
    assign period_eff_s = (bit_period_r < MIN_PERIOD) ? MIN_PERIOD : bit_period_r;

    // Per-address error decision; tx_data accepts a write if the shifter frees hold this edge.
    always_comb begin
        err_s = 1'b0;
        case (apb.paddr)
            ADDR_STATUS: err_s = apb.pwrite;
            ADDR_ERROR:  err_s = apb.pwrite;
            ADDR_BP_LO:  err_s = 1'b0;
            ADDR_BP_HI:  err_s = 1'b0;
            ADDR_DSIZE:  err_s = apb.pwrite & ~is_valid_size(apb.pwdata[3:0]);
            ADDR_TXDATA: err_s = apb.pwrite ? (hold_full_r & ~load_ack_s) : 1'b1;
            ADDR_RSVD5:  err_s = 1'b1;
            ADDR_RSVD7:  err_s = 1'b1;
            default:     err_s = 1'b1;
        endcase
    end

    // Read mux, zero outside a read.
    always_comb begin
        rdata_s = 8'd0;
        if (rd_s) begin
            case (apb.paddr)
                ADDR_STATUS: rdata_s = {6'd0, hold_full_r, busy_s};
                ADDR_ERROR:  rdata_s = {7'd0, overrun_r};
                ADDR_BP_LO:  rdata_s = bit_period_r[7:0];
                ADDR_BP_HI:  rdata_s = {2'd0, bit_period_r[13:8]};
                ADDR_DSIZE:  rdata_s = {4'd0, data_size_r};
                default:     rdata_s = 8'd0;
            endcase
        end else begin
            rdata_s = 8'd0;
        end
    end

    assign apb.prdata  = rdata_s;
    assign apb.pslverr = access_s & err_s;

    // Configuration registers, updated only by error-free writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_period_r <= RST_BIT_PERIOD;
            data_size_r  <= RST_DATA_SIZE;
        end else if (wr_s && !err_s) begin
            case (apb.paddr)
                ADDR_BP_LO: bit_period_r[7:0]  <= apb.pwdata;
                ADDR_BP_HI: bit_period_r[13:8] <= apb.pwdata[5:0];
                ADDR_DSIZE: data_size_r        <= apb.pwdata[3:0];
                default:    bit_period_r       <= bit_period_r;
            endcase
        end
    end

    // Holding register and sticky overrun; a new write wins over the shifter's take.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_r <= 1'b0;
            hold_data_r <= 8'd0;
            overrun_r   <= 1'b0;
        end else begin
            if (wr_s && (apb.paddr == ADDR_TXDATA) && !err_s) begin
                hold_full_r <= 1'b1;
                hold_data_r <= apb.pwdata;
            end else if (load_ack_s) begin
                hold_full_r <= 1'b0;
            end

            if (wr_s && (apb.paddr == ADDR_TXDATA) && err_s) begin
                overrun_r <= 1'b1;
            end else if (access_s && !apb.pwrite && (apb.paddr == ADDR_ERROR)) begin
                overrun_r <= 1'b0;
            end
        end
    end

    uart_tx_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load_req    (hold_full_r),
        .load_byte   (hold_data_r),
        .load_size   (data_size_r),
        .load_period (period_eff_s),
        .load_ack    (load_ack_s),
        .busy        (busy_s),
        .serial_out  (serial_out)
    );

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed bench for apb_uart_tx: register access, frame timing, back-to-back,
// overrun, error responses and reset mid-frame.
module tb_apb_uart_tx;

    logic clk;
    logic rst;
    logic serial_out;
    int   n_assert;
    int   n_fail;

    apb_uart_tx_if bus ();

    apb_uart_tx #(
        .RST_BIT_PERIOD (14'd10),
        .RST_DATA_SIZE  (4'd8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .apb        (bus),
        .serial_out (serial_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [2:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic err);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.paddr = a; bus.pwrite = wr; bus.pwdata = d; bus.penable = 1'b0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        rd  = bus.prdata;
        err = bus.pslverr;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [2:0] a, input logic [7:0] d, input logic exp_err);
        logic [7:0] r;
        logic e;
        apb(1'b1, a, d, r, e);
        chk({tag, "_err"}, {15'd0, e}, {15'd0, exp_err});
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp_data, input logic exp_err);
        logic [7:0] r;
        logic e;
        apb(1'b0, a, 8'd0, r, e);
        chk({tag, "_data"}, {8'd0, r}, {8'd0, exp_data});
        chk({tag, "_err"}, {15'd0, e}, {15'd0, exp_err});
    endtask

    // Checks one frame starting at the next clock edge.
    task automatic check_frame(input string tag, input logic [7:0] b, input int size, input int p);
        int k;
        logic exp;
        for (int i = 0; i < (size + 2) * p; i++) begin
            @(posedge clk); #1;
            k = i / p;
            if (k == 0)          exp = 1'b0;
            else if (k <= size)  exp = b[k-1];
            else                 exp = 1'b1;
            chk(tag, {15'd0, serial_out}, {15'd0, exp});
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 3'd0; bus.pwdata = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_serial", {15'd0, serial_out}, 16'h0001);
        chk("idle_prdata", {8'd0, bus.prdata}, 16'h0000);
        chk("idle_pslverr", {15'd0, bus.pslverr}, 16'h0000);
        rd_chk("rst_bp_lo", 3'd2, 8'h0A, 1'b0);
        rd_chk("rst_bp_hi", 3'd3, 8'h00, 1'b0);
        rd_chk("rst_dsize", 3'd4, 8'h08, 1'b0);
        rd_chk("rst_status", 3'd0, 8'h00, 1'b0);
        rd_chk("rst_error", 3'd1, 8'h00, 1'b0);

        // Single frame 0xA5, P=4, 8 bits
        wr_chk("wr_bp_lo", 3'd2, 8'd4, 1'b0);
        wr_chk("wr_dsize8", 3'd4, 8'd8, 1'b0);
        rd_chk("bp_lo_rb", 3'd2, 8'h04, 1'b0);
        wr_chk("wr_a5", 3'd6, 8'hA5, 1'b0);
        check_frame("frame_a5", 8'hA5, 8, 4);
        @(posedge clk); #1;
        chk("after_a5_idle", {15'd0, serial_out}, 16'h0001);

        // Back-to-back frames with overrun attempt while hold is full
        wr_chk("wr_3c", 3'd6, 8'h3C, 1'b0);
        fork
            begin
                check_frame("frame_3c", 8'h3C, 8, 4);
                check_frame("frame_c3", 8'hC3, 8, 4);
            end
            begin
                wr_chk("wr_c3", 3'd6, 8'hC3, 1'b0);
                rd_chk("status_full", 3'd0, 8'h03, 1'b0);
                wr_chk("wr_overrun", 3'd6, 8'h55, 1'b1);
                rd_chk("overrun_set", 3'd1, 8'h01, 1'b0);
                rd_chk("overrun_clr", 3'd1, 8'h00, 1'b0);
                repeat (30) @(posedge clk);
                #1;
                rd_chk("status_loaded", 3'd0, 8'h01, 1'b0);
            end
        join
        @(posedge clk); #1;
        chk("after_c3_idle", {15'd0, serial_out}, 16'h0001);
        rd_chk("status_idle", 3'd0, 8'h00, 1'b0);

        // Error responses
        wr_chk("wr_dsize6", 3'd4, 8'd6, 1'b1);
        rd_chk("dsize_kept", 3'd4, 8'h08, 1'b0);
        rd_chk("rd_rsvd5", 3'd5, 8'h00, 1'b1);
        wr_chk("wr_rsvd5", 3'd5, 8'h12, 1'b1);
        wr_chk("wr_rsvd7", 3'd7, 8'h34, 1'b1);
        rd_chk("rd_txdata", 3'd6, 8'h00, 1'b1);
        wr_chk("wr_status", 3'd0, 8'hFF, 1'b1);
        wr_chk("wr_error", 3'd1, 8'hFF, 1'b1);
        rd_chk("error_untouched", 3'd1, 8'h00, 1'b0);

        // Period clamp (bit_period=1 -> 2 clocks) and 5-bit characters
        wr_chk("wr_bp_1", 3'd2, 8'd1, 1'b0);
        wr_chk("wr_dsize5", 3'd4, 8'd5, 1'b0);
        rd_chk("dsize5_rb", 3'd4, 8'h05, 1'b0);
        wr_chk("wr_f2", 3'd6, 8'hF2, 1'b0);
        check_frame("frame_f2_5b", 8'hF2, 5, 2);
        @(posedge clk); #1;
        chk("after_f2_idle", {15'd0, serial_out}, 16'h0001);

        // Reset in the middle of the data bits
        wr_chk("wr_bp_4", 3'd2, 8'd4, 1'b0);
        wr_chk("wr_dsize8b", 3'd4, 8'd8, 1'b0);
        wr_chk("wr_00", 3'd6, 8'h00, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_data_low", {15'd0, serial_out}, 16'h0000);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_serial", {15'd0, serial_out}, 16'h0001);
        rst = 1'b0;
        rd_chk("rst_mid_status", 3'd0, 8'h00, 1'b0);
        rd_chk("rst_mid_bp", 3'd2, 8'h0A, 1'b0);
        wr_chk("wr_5a", 3'd6, 8'h5A, 1'b0);
        check_frame("frame_5a_p10", 8'h5A, 8, 10);
        @(posedge clk); #1;
        chk("final_idle", {15'd0, serial_out}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_uart_tx.md
Name: apb_uart_tx

Overview:
APB-programmable UART transmitter; the transmit-side counterpart of the team's APB UART receiver, using the same APB slave style, register conventions and frame format. Software configures bit period and data size over APB, writes bytes to a one-entry holding register, and the block serialises them as start / data (LSB first) / stop on serial_out. It sits beside the receiver on the same APB bus segment.

Parameters:
RST_BIT_PERIOD, 14'd10, bit_period reset value (clocks per serial bit)
RST_DATA_SIZE, 4'd8, data_size reset value

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
psel  input  1  APB select
paddr  input  3  APB register address
penable  input  1  APB access phase
pwrite  input  1  APB direction, 1 = write
pwdata  input  8  APB write data
prdata  output  8  APB read data
pslverr  output  1  APB error response
serial_out  output  1  UART line, idle high

Behaviour:
- Reset (rst high at a clock edge): serial_out=1, shifter IDLE, holding empty, overrun flag=0, bit_period=RST_BIT_PERIOD, data_size=RST_DATA_SIZE. prdata/pslverr are combinational and read 0 while psel=0. Reset mid-frame aborts the frame; serial_out returns to 1 on the same edge.
- APB: no wait states. Register write commits on the edge where psel&penable&pwrite. prdata = selected register when psel&!pwrite, else 0. pslverr asserted combinationally during psel&penable for an errored access. An errored write changes no state.
- Register map:
  - 0: status, RO: bit0 tx_busy (shifter not IDLE), bit1 hold_full.
  - 1: error, RO: bit0 overrun. Sticky; cleared on the edge completing a read (psel&penable&!pwrite).
  - 2: bit_period[7:0], RW.
  - 3: bit_period[13:8] in pwdata[5:0], RW; upper bits read 0.
  - 4: data_size[3:0], RW. Only 5, 7 and 8 are accepted; any other value gives pslverr and is not stored.
  - 6: tx_data, WO. A read gives pslverr with prdata 0.
  - 5, 7: reserved. Any access gives pslverr.
- Writes to 0 or 1 give pslverr.
- Holding register:
  - A write to 6 while hold is empty loads it.
  - A write to 6 while hold is full sets overrun, asserts pslverr and discards the data.
  - A write to 6 on the same edge that the shifter empties hold is accepted.
- Shifter FSM (IDLE, START, DATA, STOP):
  - IDLE: if hold_full, latch hold byte, data_size and effective period; clear hold; go to START. serial_out=1.
  - START: serial_out=0 for P clocks, then DATA.
  - DATA: serial_out=shift[0] for P clocks per bit, shift right; after data_size bits, go to STOP.
  - STOP: serial_out=1 for P clocks. Then:
    - if hold_full, load directly into START (back-to-back, no idle gap);
    - else go to IDLE.
- Effective period P = bit_period, except bit_period < 2 gives P = 2. The bit counter is 14-bit and counts P-1 down to 0.
- Latency: APB write to 6 commits at edge N with the shifter idle. The shifter loads at edge N+1; serial_out falls at edge N+1 and stays low for P clocks.
- Configuration changes while busy affect only the next frame. data_size 5/7 sends the low bits of the byte; upper bits are ignored.
- Frame length: (data_size+2)*P clocks.

Decomposition:
- Package uart_pkg: register address localparams (ADDR_STATUS=0 … ADDR_TXDATA=6), tx_state_t enum {IDLE, START, DATA, STOP}, valid data_size constants.
- Sub-module uart_tx_shifter: FSM, bit counter, shift register. It takes a load strobe, byte, data_size and period, and returns busy and serial_out.
- apb_uart_tx keeps the APB decode, config registers, holding register and overrun flag.

Test Plan:
- Reset, then read addr 2/3/4 -> 0x0A, 0x00, 0x08; serial_out=1; status=0x00.
- Write bit_period=4, data_size=8, tx_data=0xA5 -> serial_out over 40 clocks: 0, then 1,0,1,0,0,1,0,1, then 1 (4 clocks each); status bit0 high during frame.
- Write 0x3C then 0xC3 immediately -> second frame starts on the clock after the first stop bit ends; no idle gap; status bit1 clears when the shifter loads.
- With hold full and shifter busy, write 0x55 -> pslverr=1; overrun read as 0x01 then 0x00 on re-read; transmitted frames unchanged.
- Write data_size=6 -> pslverr=1, readback 8. Access addr 5 or 7 -> pslverr. Read addr 6 -> pslverr, prdata 0.
- Assert rst mid-DATA -> serial_out=1 next edge, status=0; a new write afterwards transmits a correct full frame.
